// File: rtl/uart_tx_pkg.sv
// Shared definitions for the configurable UART transmitter: FSM encoding and parity constants.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Initial value of the parity accumulator so that XOR of the data bits yields the requested parity.
  function automatic logic parity_seed(logic par_type);
    logic seed;
    seed = 1'b0;
    if (par_type == PAR_ODD) begin
      seed = 1'b1;
    end else if (par_type == PAR_EVEN) begin
      seed = 1'b0;
    end
    return seed;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO; pointers carry one extra wrap bit to tell full from empty.
module uart_tx_fifo #(
  parameter int unsigned D_WIDTH    = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic               rd_en,
  output logic [D_WIDTH-1:0] rd_data_c,
  output logic               full_c,
  output logic               empty_c
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [D_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               do_wr;
  logic               do_rd;

  assign full_c    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty_c   = (wr_ptr == rd_ptr);
  assign do_wr     = wr_en && !full_c;
  assign do_rd     = rd_en && !empty_c;
  assign rd_data_c = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PW'(1);
      if (do_rd) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: emptiness is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with run-time parity/stop configuration, snapshotted per frame at pop time.
module uart_tx_cfg
  import uart_tx_pkg::*;
#(
  parameter int unsigned D_WIDTH    = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] P_Data,
  input  logic               Data_valid,
  output logic               Data_ready,
  input  logic               Par_en,
  input  logic               Par_type,
  input  logic               Stop2,
  output logic               TX_OUT,
  output logic               busy,
  output logic               tx_done
);

  localparam int unsigned CW = $clog2(D_WIDTH);

  tx_state_e          state;
  tx_state_e          state_nxt;
  logic [D_WIDTH-1:0] shreg;
  logic [CW-1:0]      bit_cnt;
  logic               par_acc;
  logic               snap_par_en;
  logic               snap_stop2;

  logic [D_WIDTH-1:0] fifo_data_c;
  logic               fifo_full_c;
  logic               fifo_empty_c;
  logic               push_c;
  logic               pop_c;
  logic               line_c;
  logic               busy_c;
  logic               frame_end_c;
  logic               last_bit_c;

  assign Data_ready = !fifo_full_c;
  assign push_c     = Data_valid && !fifo_full_c;
  assign last_bit_c = (bit_cnt == CW'(D_WIDTH - 1));

  uart_tx_fifo #(
    .D_WIDTH   (D_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .wr_en    (push_c),
    .wr_data  (P_Data),
    .rd_en    (pop_c),
    .rd_data_c(fifo_data_c),
    .full_c   (fifo_full_c),
    .empty_c  (fifo_empty_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty_c) state_nxt = START;
      START:   state_nxt = DATA;
      DATA:    if (last_bit_c) state_nxt = snap_par_en ? PARITY : STOP1;
      PARITY:  state_nxt = STOP1;
      STOP1: begin
        if (snap_stop2)         state_nxt = STOP2;
        else if (!fifo_empty_c) state_nxt = START;
        else                    state_nxt = IDLE;
      end
      STOP2:   state_nxt = fifo_empty_c ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  // Line level, pop strobe and status for the current state; registered below.
  always_comb begin
    line_c      = 1'b1;
    busy_c      = 1'b1;
    frame_end_c = 1'b0;
    pop_c       = 1'b0;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        pop_c  = !fifo_empty_c;
      end
      START:  line_c = 1'b0;
      DATA:   line_c = shreg[0];
      PARITY: line_c = par_acc;
      STOP1: begin
        frame_end_c = !snap_stop2;
        pop_c       = !snap_stop2 && !fifo_empty_c;
      end
      STOP2: begin
        frame_end_c = 1'b1;
        pop_c       = !fifo_empty_c;
      end
      default: begin
        busy_c = 1'b0;
      end
    endcase
  end

  // Shift register, bit counter, parity accumulator and per-frame configuration snapshot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      par_acc     <= 1'b0;
      snap_par_en <= 1'b0;
      snap_stop2  <= 1'b0;
    end else if (pop_c) begin
      shreg       <= fifo_data_c;
      bit_cnt     <= '0;
      par_acc     <= parity_seed(Par_type);
      snap_par_en <= Par_en;
      snap_stop2  <= Stop2;
    end else if (state == DATA) begin
      shreg   <= shreg >> 1;
      par_acc <= par_acc ^ shreg[0];
      bit_cnt <= bit_cnt + CW'(1);
    end
  end

  // Status flags share the line register stage so they stay aligned with TX_OUT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      TX_OUT  <= 1'b1;
      busy    <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      TX_OUT  <= line_c;
      busy    <= busy_c;
      tx_done <= frame_end_c;
    end
  end

endmodule
